// File: rtl/mac_sequencer.sv
// mac_sequencer: microcoded multiply-accumulate engine for the DSP audio path.
// Each start runs a program from coefficient ROM through a six-stage pipeline
// (F, D, A, M, X, W), one instruction per cycle with no stalls.
// Optional build macro MAC_SEQUENCER_SAT_EN: when defined, SAVE saturates to
// 16 signed bits; otherwise SAVE truncates.
module mac_sequencer #(
    parameter int unsigned CHAN_W  = 3,
    parameter int unsigned FRAME_W = 4,
    parameter int unsigned CODE_W  = 8,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned OUT_W   = 4
) (
    input  logic                        ck,
    input  logic                        rst,
    input  logic                        start,
    input  logic [FRAME_W-1:0]          frame,
    output logic [CODE_W-1:0]           coef_addr,
    input  logic [31:0]                 coef_data,
    output logic [CHAN_W+FRAME_W-1:0]   audio_raddr,
    input  logic signed [15:0]          audio_in,
    output logic [OUT_W-1:0]            out_addr,
    output logic [15:0]                 out_audio,
    output logic                        out_we,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam int unsigned AW       = CHAN_W + FRAME_W;
    localparam int unsigned MaxShift = (ACC_W - 16) / 4;

    localparam logic [3:0] OpHalt = 4'd0;
    localparam logic [3:0] OpMac  = 4'd1;
    localparam logic [3:0] OpMacz = 4'd2;
    localparam logic [3:0] OpMsub = 4'd3;
    localparam logic [3:0] OpSave = 4'd4;
    localparam logic [3:0] OpNop  = 4'd5;

    localparam logic [CODE_W-1:0] CodeMax = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e               state;
    logic                 d_pend;      // coef_data holds a live fetch this cycle
    logic                 d_last;      // that fetch came from the last ROM word
    logic [FRAME_W-1:0]   frame_q;
    logic [1:0]           drain_cnt;
    logic                 abort_q;

    // D stage: decode the instruction word straight off the ROM
    logic [3:0]           d_op;
    logic [15:0]          d_gain;
    logic [CHAN_W-1:0]    d_chan;
    logic [FRAME_W-1:0]   d_off;
    logic                 d_live, d_abort, d_stop, d_exec;

    assign d_op   = coef_data[31:28];
    assign d_gain = coef_data[15:0];
    assign d_chan = coef_data[16 +: CHAN_W];
    assign d_off  = coef_data[16+CHAN_W +: FRAME_W];

    if (AW < 12) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^coef_data[27:16+AW];
    end

    assign d_live  = (state == StRun) && d_pend;
    assign d_abort = (d_op > OpNop)
                   || ((d_op == OpSave) && (32'(d_off) > MaxShift))
                   || (d_last && (d_op != OpHalt));
    assign d_stop  = (d_op == OpHalt) || d_abort;
    assign d_exec  = d_live && !d_stop;

    // Sequencer FSM: fetch control plus the registered status outputs
    always_ff @(posedge ck) begin
        if (!rst) begin
            state     <= StIdle;
            coef_addr <= '0;
            d_pend    <= 1'b0;
            d_last    <= 1'b0;
            frame_q   <= '0;
            drain_cnt <= '0;
            abort_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            d_pend <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StRun;
                        coef_addr <= '0;
                        frame_q   <= frame;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                StRun: begin
                    if (d_pend && d_stop) begin
                        // Three more cycles lets the last real op clear W
                        state     <= StDrain;
                        drain_cnt <= 2'd2;
                        abort_q   <= d_abort;
                    end else begin
                        d_pend    <= 1'b1;
                        d_last    <= (coef_addr == CodeMax);
                        if (coef_addr != CodeMax) begin
                            coef_addr <= coef_addr + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (drain_cnt == 2'd0) begin
                        state     <= StIdle;
                        coef_addr <= '0;
                        busy      <= 1'b0;
                        done      <= !abort_q;
                        error     <= abort_q;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // A, M and X stage registers
    logic                       a_valid, m_valid, x_valid;
    logic [3:0]                 a_op, m_op, x_op;
    logic [15:0]                a_gain;
    logic signed [15:0]         m_gain;
    logic [FRAME_W-1:0]         a_shift, m_shift, x_shift;
    logic [CHAN_W-1:0]          a_chan, m_chan, x_chan;
    logic signed [31:0]         x_prod;
    logic signed [ACC_W-1:0]    acc;

    logic signed [31:0]         m_prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_shr;
    logic [15:0]                save_val;

    assign m_prod   = m_gain * audio_in;
    assign prod_ext = ACC_W'(x_prod);
    assign acc_shr  = acc >>> {x_shift, 2'b00};

`ifdef MAC_SEQUENCER_SAT_EN
    // Result fits when every bit from 4s+15 upward matches the sign
    logic [ACC_W-16:0] sat_hi;
    assign sat_hi   = acc_shr[ACC_W-1:15];
    assign save_val = ((&sat_hi) || !(|sat_hi)) ? acc_shr[15:0]
                    : (acc[ACC_W-1] ? 16'h8000 : 16'h7FFF);
`else
    logic unused_shr;
    assign unused_shr = ^acc_shr[ACC_W-1:16];
    assign save_val   = acc_shr[15:0];
`endif

    // Datapath: address generation, product, accumulate and write-back
    always_ff @(posedge ck) begin
        if (!rst) begin
            a_valid     <= 1'b0;
            m_valid     <= 1'b0;
            x_valid     <= 1'b0;
            a_op        <= '0;
            m_op        <= '0;
            x_op        <= '0;
            a_gain      <= '0;
            m_gain      <= '0;
            a_shift     <= '0;
            m_shift     <= '0;
            x_shift     <= '0;
            a_chan      <= '0;
            m_chan      <= '0;
            x_chan      <= '0;
            x_prod      <= '0;
            acc         <= '0;
            audio_raddr <= '0;
            out_we      <= 1'b0;
            out_addr    <= '0;
            out_audio   <= '0;
        end else begin
            a_valid <= d_exec;
            a_op    <= d_op;
            a_gain  <= d_gain;
            a_shift <= d_off;
            a_chan  <= d_chan;
            if (d_exec) begin
                audio_raddr <= {d_chan, frame_q + d_off};
            end else if (state == StDrain && drain_cnt == 2'd0) begin
                audio_raddr <= '0;
            end

            m_valid <= a_valid;
            m_op    <= a_op;
            m_gain  <= a_gain;
            m_shift <= a_shift;
            m_chan  <= a_chan;

            x_valid <= m_valid;
            x_op    <= m_op;
            x_prod  <= m_prod;
            x_shift <= m_shift;
            x_chan  <= m_chan;

            out_we    <= 1'b0;
            out_addr  <= '0;
            out_audio <= '0;
            if (x_valid) begin
                case (x_op)
                    OpMac:  acc <= acc + prod_ext;
                    OpMacz: acc <= prod_ext;
                    OpMsub: acc <= acc - prod_ext;
                    OpSave: begin
                        out_we    <= 1'b1;
                        out_addr  <= OUT_W'(x_chan);
                        out_audio <= save_val;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Parametrised microcoded multiply-accumulate engine for the DSP audio path, single-clock successor to the frame sequencer. On each `start` it runs a program from coefficient ROM. Each step reads one sample from the multichannel audio frame buffer, multiplies it by a signed gain, and accumulates the result. Save steps shift, optionally saturate, and write results to the output bank.

## Interface
- `CHAN_W`, 3, audio channel index width (CHAN_W+FRAME_W ≤ 12)
- `FRAME_W`, 4, frame-history index width
- `CODE_W`, 8, program address width
- `ACC_W`, 40, accumulator width (≥ 32, multiple of 4)
- `OUT_W`, 4, output-bank address width (≤ CHAN_W+FRAME_W)
- `ck`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-low
- `start`  in  1  run-program strobe; ignored while `busy`
- `frame`  in  FRAME_W  current write position of the audio buffer; sampled on `start`
- `coef_addr`  out  CODE_W  program ROM address
- `coef_data`  in  32  instruction; ROM read latency 1 cycle
- `audio_raddr`  out  CHAN_W+FRAME_W  audio buffer read address {chan, frame+offset}
- `audio_in`  in  16  signed sample; read latency 1 cycle
- `out_addr`  out  OUT_W  output bank address
- `out_audio`  out  16  signed result
- `out_we`  out  1  output write strobe, one cycle per SAVE
- `busy`  out  1  program running or pipeline draining
- `done`  out  1  program finished; held until next accepted `start`
- `error`  out  1  program aborted; held until next accepted `start`

## Operation
- Instruction fields:
  - gain = [15:0]
  - chan = [16+CHAN_W-1:16]
  - offset = next FRAME_W bits
  - op = [31:28]
- op 0 HALT: stop fetch, drain, then `done`.
- op 1 MAC: acc += gain×sample.
- op 2 MACZ: acc = gain×sample.
- op 3 MSUB: acc −= gain×sample.
- op 4 SAVE: write acc >> (4·offset) to out_addr = low OUT_W bits of {offset,chan}… no: out_addr = chan field zero-extended. acc is unchanged.
- op 5 NOP: no effect.
- ops 6–15 illegal: set `error`, halt.
- Product is 16×16 signed → 32 bits, sign-extended to ACC_W. The accumulator wraps modulo 2^ACC_W.
- SAVE shift amount s = offset. If 4s+16 > ACC_W, set `error` and halt; no write occurs.
- Sample address = {chan, frame_latched + offset}. The frame sum wraps modulo 2^FRAME_W.
- Pipeline stages, one instruction per cycle, no stalls:
  - F: coef_addr
  - D: instruction registered
  - A: audio_raddr registered
  - M: sample registered, product registered
  - X: accumulate, or SAVE shift/saturate register
  - W: out_we
- SAVE in X sees all earlier MACs, so there are no hazards.
- Instructions fetched after a HALT or an illegal op are squashed.
- If coef_addr reaches 2^CODE_W−1 and that word is not HALT, set `error` and halt (no wrap).
- States:
  - IDLE → (start) → RUN
  - RUN → (HALT or error decoded) → DRAIN
  - DRAIN → (pipeline empty) → IDLE, asserting `done` or `error`
- Reset mid-run returns to IDLE immediately. In-flight instructions are discarded, with no `out_we`.

## Timing
- Reset values:
  - coef_addr 0, audio_raddr 0
  - out_addr 0, out_audio 0, out_we 0
  - busy 0, done 0, error 0
  - accumulator 0
- `start` accepted at edge t. Then:
  - `busy`=1 and coef_addr=0 from t+1.
  - Instruction k is fetched at t+1+k.
  - A SAVE at address k drives out_we high during cycle t+6+k.
- out_addr and out_audio are valid only while out_we=1; otherwise they are 0.
- audio_raddr is 0 whenever not in RUN/DRAIN.
- Completion timing for a HALT at address h:
  - `busy` falls at t+h+6.
  - `done` rises in the same cycle.
  - `error` rises at the same point when the abort was an illegal op.
- `start` during `busy` is ignored. A `start` in the same cycle `busy` falls is accepted and clears done/error.

## Configuration
- `MAC_SEQUENCER_SAT_EN`:
  - Defined: SAVE saturates. If acc bits above 4s+15 are not all equal to the sign bit, the output is 16'h7FFF (positive) or 16'h8000 (negative).
  - Undefined: SAVE truncates to acc[4s+15:4s].

## Test plan
- Program MACZ g=0x4000 ch0 off0, SAVE s=4 ch2, HALT; sample 0x1000 → out_we once at t+7, out_addr=2, out_audio=0x0400, done at t+8.
- MACZ g=0x7FFF ×0x7FFF, MAC ×3 same, SAVE s=0 → SAT_EN: 0x7FFF; no SAT_EN: truncated low 16 bits of 0x0FFFC0004 = 0x0004.
- MACZ g=0x0100 ×0x0100, MSUB g=0x0200 ×0x0100, SAVE s=2 → out_audio=0xFF00 (−256).
- frame=15, MAC off=3 chan=5 → audio_raddr={5,2}.
- Op 0x9 at address 3 → error=1, done=0, no writes from later SAVEs, busy falls at t+9.
- rst low mid-program for one cycle → all outputs 0 next edge, no out_we. A new start then runs cleanly from address 0.
